// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU data port, the DMA/loader port and the data SRAM.
// The arbiter takes the slave side; the top level (or a bench) drives the master side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              cpu_cs;
  logic              cpu_r;
  logic              cpu_w;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output ram_a, ram_d, ram_we,
    input  ram_q
  );

  modport master (
    output cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  ram_a, ram_d, ram_we,
    output ram_q
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single data SRAM between the CPU data port (priority) and the DMA port,
// with a starvation counter that guarantees the DMA a slot after CPU_MAX CPU grants.
module dmem_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int CPU_MAX = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  dmem_arbiter_if.slave    bus
);
  localparam logic [3:0] CNT_MAX = 4'(CPU_MAX);

  logic [3:0]        starve_cnt;
  logic              cpu_req;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic              starved;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

  assign cpu_req = bus.cpu_cs & (bus.cpu_r | bus.cpu_w);
  assign starved = (starve_cnt == CNT_MAX);
  assign dma_gnt = bus.dma_req & (~cpu_req | starved);
  assign cpu_gnt = cpu_req & ~dma_gnt;

  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_stall  = cpu_req & ~cpu_gnt;
  assign bus.cpu_rdata  = bus.ram_q;
  assign bus.ram_a      = ram_a;
  assign bus.ram_d      = ram_d;
  assign bus.ram_we     = ram_we;
  assign bus.dma_rdata  = dma_rdata;
  assign bus.dma_rvalid = dma_rvalid;

  // A CPU access with both strobes high writes, since cpu_w alone selects the write enable.
  always_comb begin
    ram_a  = '0;
    ram_d  = '0;
    ram_we = 1'b0;
    if (dma_gnt) begin
      ram_a  = bus.dma_addr;
      ram_d  = bus.dma_wdata;
      ram_we = bus.dma_we;
    end else if (cpu_gnt) begin
      ram_a  = bus.cpu_addr[ADDR_W+1:2];
      ram_d  = bus.cpu_wdata;
      ram_we = bus.cpu_w;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      starve_cnt <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_gnt & ~bus.dma_we;
      if (dma_gnt & ~bus.dma_we) begin
        dma_rdata <= bus.ram_q;
      end
      if (dma_gnt) begin
        starve_cnt <= '0;
      end else if (cpu_gnt & bus.dma_req) begin
        starve_cnt <= starved ? CNT_MAX : starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps followed by protocol-respecting
// random traffic, compared each cycle against a behavioural model of the sharing rules.
module tb_dmem_arbiter;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 32;
  localparam int CPU_MAX = 4;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  always #5 clk_in = ~clk_in;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_MAX(CPU_MAX)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  // Distributed SRAM seen by the arbiter: asynchronous read, write on the rising edge.
  logic [DATA_W-1:0] tb_mem [0:(1<<ADDR_W)-1] = '{default: '0};
  assign bus.ram_q = tb_mem[bus.ram_a];
  always @(posedge clk_in) begin
    if (bus.ram_we) tb_mem[bus.ram_a] <= bus.ram_d;
  end

  logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1] = '{default: '0};
  int                model_starve = 0;
  logic [DATA_W-1:0] model_rdata  = '0;
  logic              model_rvalid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check the combinational view, clock, check the registered view.
  task automatic apply_stimulus(
    input  logic              rst_n,
    input  logic              cs, r, w,
    input  logic [31:0]       caddr,
    input  logic [DATA_W-1:0] cwdata,
    input  logic              dreq, dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic              dma_won
  );
    logic              creq, dwin, cgnt, ewe;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    reset         = rst_n;
    bus.cpu_cs    = cs;
    bus.cpu_r     = r;
    bus.cpu_w     = w;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwdata;
    bus.dma_req   = dreq;
    bus.dma_we    = dwe;
    bus.dma_addr  = daddr;
    bus.dma_wdata = dwdata;
    #3;
    creq = cs && (r || w);
    dwin = dreq && (!creq || model_starve >= CPU_MAX);
    cgnt = creq && !dwin;
    if (dwin) begin
      ea = daddr; ed = dwdata; ewe = dwe;
    end else if (cgnt) begin
      ea = caddr[ADDR_W+1:2]; ed = cwdata; ewe = w;
    end else begin
      ea = '0; ed = '0; ewe = 1'b0;
    end
    check_output("dma_gnt",   32'(bus.dma_gnt),   32'(dwin));
    check_output("cpu_stall", 32'(bus.cpu_stall), 32'(creq && !cgnt));
    check_output("ram_a",     32'(bus.ram_a),     32'(ea));
    check_output("ram_d",     bus.ram_d,          ed);
    check_output("ram_we",    32'(bus.ram_we),    32'(ewe));
    check_output("cpu_rdata", bus.cpu_rdata,      model_mem[ea]);
    @(posedge clk_in);
    if (!rst_n) begin
      model_rvalid = 1'b0;
      model_rdata  = '0;
      model_starve = 0;
    end else begin
      model_rvalid = dwin && !dwe;
      if (dwin && !dwe) model_rdata = model_mem[daddr];
      if (dwin)                model_starve = 0;
      else if (cgnt && dreq)   model_starve = (model_starve + 1 > CPU_MAX) ? CPU_MAX : model_starve + 1;
      else                     model_starve = 0;
    end
    if (ewe) model_mem[ea] = ed;
    #1;
    check_output("dma_rvalid", 32'(bus.dma_rvalid), 32'(model_rvalid));
    check_output("dma_rdata",  bus.dma_rdata,       model_rdata);
    dma_won = dwin;
  endtask

  initial begin
    logic              won;
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wd;
    logic [31:0]       caddr;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;

    bus.cpu_cs = 0; bus.cpu_r = 0; bus.cpu_w = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    reset = 1'b0;
    @(posedge clk_in); #1;
    check_output("reset_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check_output("reset_rdata",  bus.dma_rdata,       32'd0);

    $display("[TB] reset with both ports requesting");
    repeat (2) apply_stimulus(0, 1, 1, 0, 32'h10, 0, 1, 0, 11'd7, 0, won);
    apply_stimulus(1, 1, 1, 0, 32'h10, 0, 1, 0, 11'd7, 0, won);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, won);

    $display("[TB] CPU-only write then read");
    apply_stimulus(1, 1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, won);
    apply_stimulus(1, 1, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0, won);

    $display("[TB] DMA-only write then read");
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 11'd7, 32'h12345678, won);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 11'd7, 0, won);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, won);

    $display("[TB] starvation bound with both ports saturated");
    repeat (12) apply_stimulus(1, 1, 1, 0, 32'h10, 0, 1, 0, 11'd7, 0, won);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, won);

    $display("[TB] CPU read must not write");
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 11'd3, 32'hA5A5A5A5, won);
    apply_stimulus(1, 1, 1, 0, 32'hC, 32'h0, 0, 0, 0, 0, won);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 11'd3, 0, won);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, won);

    $display("[TB] reset in the middle of a contended burst");
    repeat (3) apply_stimulus(1, 1, 1, 0, 32'h10, 0, 1, 0, 11'd3, 0, won);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 11'd3, 0, won);
    repeat (6) apply_stimulus(1, 1, 0, 1, 32'h20, 32'h0BADF00D, 1, 0, 11'd3, 0, won);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if (!p_req) begin
        p_req  = ($urandom_range(0, 2) != 0);
        p_we   = 1'($urandom_range(0, 1));
        p_addr = ADDR_W'($urandom_range(0, 15));
        p_wd   = $urandom;
      end
      caddr = $urandom;
      caddr[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
      apply_stimulus(($urandom_range(0, 39) != 0),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     caddr, $urandom, p_req, p_we, p_addr, p_wd, won);
      if (won) p_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
